// File: rtl/sync_packet_fifo.sv
// Purpose : synchronous AXI-Stream FIFO with tlast framing, occupancy level and
//           almost-full/almost-empty flags; optional store-and-forward (PACKET=1).
// Latency : first-word fall-through; a beat written into an empty FIFO shows on
//           m_tvalid one cycle after acceptance (after its tlast beat in packet mode).
// Backpressure: s_tready is registered and drops once DEPTH beats are held; the
//           output register holds its beat stable until m_tready.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   level_o               beats held (SRAM + output register), 0..DEPTH
//   afull_o / aempty_o    level_o >= AFULL / level_o <= AEMPTY
//   oversize_o            one-cycle pulse when a packet larger than the FIFO
//                         is force-committed
//   s_t*                  AXI-Stream write side
//   drop_i                discard the current uncommitted packet
//   m_t*                  AXI-Stream read side (output register)
//
// Build option: define SYNC_PACKET_FIFO_DROP_EN to enable drop_i (PACKET=1 only);
// otherwise drop_i is ignored.
module sync_packet_fifo #(
  parameter int WIDTH  = 8,
  parameter int ABITS  = 4,
  parameter int AFULL  = 12,
  parameter int AEMPTY = 2,
  parameter int PACKET = 0
) (
  input  logic             clock,
  input  logic             reset,
  output logic [ABITS:0]   level_o,
  output logic             afull_o,
  output logic             aempty_o,
  output logic             oversize_o,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             drop_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata
);

  localparam int              DEPTH    = 1 << ABITS;
  localparam logic [ABITS:0]  DEPTH_L  = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0]  AFULL_L  = (ABITS+1)'(AFULL);
  localparam logic [ABITS:0]  AEMPTY_L = (ABITS+1)'(AEMPTY);

  // {tlast, tdata} per entry
  logic [WIDTH:0] mem [DEPTH];

  logic [ABITS:0] wr_ptr;
  logic [ABITS:0] cm_ptr;
  logic [ABITS:0] rd_ptr;
  logic [ABITS:0] level_q;
  logic           forced_q;   // packet was force-committed and is still open
  logic           oversize_q;

  logic           accept_in;
  logic           accept_out;
  logic           drop_act;
  logic           force_commit;
  logic           load;
  logic [ABITS:0] limit;
  logic [ABITS:0] cm_eff;
  logic [ABITS:0] drop_cnt;
  logic [ABITS:0] wr_nxt;
  logic [ABITS:0] cm_nxt;
  logic [ABITS:0] level_nxt;
  logic           forced_nxt;

  assign accept_in  = s_tvalid && s_tready;
  assign accept_out = m_tvalid && m_tready;

`ifdef SYNC_PACKET_FIFO_DROP_EN
  assign drop_act = (PACKET != 0) && drop_i;
`else
  logic unused_drop;
  assign unused_drop = drop_i;
  assign drop_act    = 1'b0;
`endif

  // A full FIFO with nothing committed can never drain on its own: the open
  // packet is bigger than the storage, so commit what we have and let the rest
  // of the packet run cut-through.
  assign force_commit = (PACKET != 0) && (level_q == DEPTH_L) &&
                        (cm_ptr == rd_ptr) && !m_tvalid;

  // Commit point as seen by a drop in the same cycle: a force-commit wins, so
  // only beats beyond the forced commit point can be discarded.
  assign cm_eff = force_commit ? wr_ptr : cm_ptr;

  assign limit = (PACKET != 0) ? cm_ptr : wr_ptr;
  assign load  = (limit != rd_ptr) && (!m_tvalid || m_tready);

  always_comb begin
    wr_nxt     = wr_ptr;
    cm_nxt     = cm_eff;
    drop_cnt   = '0;
    forced_nxt = forced_q;
    if (force_commit) begin
      forced_nxt = 1'b1;
    end
    if (drop_act) begin
      // The beat accepted this cycle (if any) is discarded too, tlast included.
      drop_cnt = wr_ptr - cm_eff;
      wr_nxt   = cm_eff;
    end else if (accept_in) begin
      wr_nxt = wr_ptr + 1'b1;
      // While forced, every beat is committed as it arrives.
      if (s_tlast || forced_q) begin
        cm_nxt = wr_ptr + 1'b1;
      end
    end
    if (accept_in && s_tlast) begin
      forced_nxt = 1'b0;
    end
    level_nxt = level_q - drop_cnt
              - {{ABITS{1'b0}}, accept_out}
              + {{ABITS{1'b0}}, (accept_in && !drop_act)};
  end

  // Storage: no reset needed, validity is carried by the pointers.
  always_ff @(posedge clock) begin
    if (accept_in) begin
      mem[wr_ptr[ABITS-1:0]] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      level_q    <= '0;
      forced_q   <= 1'b0;
      oversize_q <= 1'b0;
      s_tready   <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      cm_ptr     <= cm_nxt;
      level_q    <= level_nxt;
      forced_q   <= forced_nxt;
      oversize_q <= force_commit;
      s_tready   <= (level_nxt < DEPTH_L);
    end
  end

  // Output register; data only changes on a load, so it stays stable while
  // the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
    end else if (load) begin
      rd_ptr              <= rd_ptr + 1'b1;
      m_tvalid            <= 1'b1;
      {m_tlast, m_tdata}  <= mem[rd_ptr[ABITS-1:0]];
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  assign level_o    = level_q;
  assign afull_o    = (level_q >= AFULL_L);
  assign aempty_o   = (level_q <= AEMPTY_L);
  assign oversize_o = oversize_q;

endmodule

// File: tb/tb_sync_packet_fifo.sv
// Bench for sync_packet_fifo: one cut-through instance (d=0) and one
// store-and-forward instance (d=1) share clock and reset. Stimulus pushes the
// expected beats into per-instance queues; a negedge monitor pops and compares.
module tb_sync_packet_fifo;

  logic clock = 1'b0;
  logic reset;

  logic [1:0]      s_tvalid;
  logic [1:0]      s_tlast;
  logic [1:0][7:0] s_tdata;
  logic [1:0]      drop_i;
  logic [1:0]      m_tready;
  logic [1:0]      s_tready;
  logic [1:0]      m_tvalid;
  logic [1:0]      m_tlast;
  logic [1:0][7:0] m_tdata;
  logic [1:0][4:0] level;
  logic [1:0]      afull;
  logic [1:0]      aempty;
  logic [1:0]      oversize;

  always #5 clock = ~clock;

  sync_packet_fifo #(.WIDTH(8), .ABITS(4), .AFULL(12), .AEMPTY(2), .PACKET(0)) u0 (
    .clock(clock), .reset(reset), .level_o(level[0]), .afull_o(afull[0]),
    .aempty_o(aempty[0]), .oversize_o(oversize[0]), .s_tvalid(s_tvalid[0]),
    .s_tready(s_tready[0]), .s_tlast(s_tlast[0]), .s_tdata(s_tdata[0]),
    .drop_i(drop_i[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]),
    .m_tlast(m_tlast[0]), .m_tdata(m_tdata[0]));

  sync_packet_fifo #(.WIDTH(8), .ABITS(4), .AFULL(12), .AEMPTY(2), .PACKET(1)) u1 (
    .clock(clock), .reset(reset), .level_o(level[1]), .afull_o(afull[1]),
    .aempty_o(aempty[1]), .oversize_o(oversize[1]), .s_tvalid(s_tvalid[1]),
    .s_tready(s_tready[1]), .s_tlast(s_tlast[1]), .s_tdata(s_tdata[1]),
    .drop_i(drop_i[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]),
    .m_tlast(m_tlast[1]), .m_tdata(m_tdata[1]));

  // Reference model: expected output beats {tlast,data} per instance, plus the
  // open (uncommitted) packet of the store-and-forward instance.
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  logic [8:0] pend[$];
  bit         forced = 0;
  int         ov_exp = 0;
  int         ov_seen[2];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         rnd_done;
  logic [1:0] held;
  logic [8:0] held_dat[2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic int held_beats(input int d);
    if (d == 0) return exp0.size();
    return exp1.size() + pend.size();
  endfunction

  task automatic flush_pend();
    while (pend.size() > 0) exp1.push_back(pend.pop_front());
  endtask

  // Packet rules: beats become visible when their tlast arrives; a packet
  // that fills the whole FIFO with nothing else waiting is committed as-is and
  // the rest of it streams straight through; a drop throws away the open part.
  task automatic model_accept(input int d, input logic [7:0] dat, input logic last, input logic drp);
    if (d == 0) begin
      exp0.push_back({last, dat});
    end else if (drp) begin
      if (!forced) pend.delete();
      if (last) forced = 0;
    end else if (forced || last) begin
      flush_pend();
      exp1.push_back({last, dat});
      if (last) forced = 0;
    end else begin
      pend.push_back({last, dat});
      if (pend.size() == 16) begin
        flush_pend();
        forced = 1;
        ov_exp++;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int d, input logic [7:0] dat, input logic last, input logic drp);
    int budget = 0;
    s_tvalid[d] = 1'b1;
    s_tdata[d]  = dat;
    s_tlast[d]  = last;
    while (!s_tready[d] && budget < 500) begin
      step();
      budget++;
    end
    if (!s_tready[d]) begin
      fail_now("push_timeout");
    end else begin
      drop_i[d] = drp;
      model_accept(d, dat, last, drp);
      step();
    end
    s_tvalid[d] = 1'b0;
    drop_i[d]   = 1'b0;
  endtask

  task automatic drain(input int d);
    int budget = 0;
    while (((d == 0) ? exp0.size() : exp1.size()) != 0 && budget < 2000) begin
      step();
      budget++;
    end
    if (((d == 0) ? exp0.size() : exp1.size()) != 0) fail_now("drain_timeout");
    repeat (2) step();
  endtask

  // Monitor: compare every output handshake against the scoreboard and check
  // the output beat is held while stalled.
  always @(negedge clock) begin
    if (reset) begin
      held = 2'b00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [8:0] got;
        got = {m_tlast[d], m_tdata[d]};
        if (held[d]) begin
          check("hold_valid", 32'(m_tvalid[d]), 32'd1);
          check("hold_data", 32'(got), 32'(held_dat[d]));
        end
        if (m_tvalid[d] && m_tready[d]) begin
          if (d == 0) begin
            if (exp0.size() == 0) fail_now("unexpected_beat0");
            else check("out_beat0", 32'(got), 32'(exp0.pop_front()));
          end else begin
            if (exp1.size() == 0) fail_now("unexpected_beat1");
            else check("out_beat1", 32'(got), 32'(exp1.pop_front()));
          end
        end
        held[d]     = m_tvalid[d] && !m_tready[d];
        held_dat[d] = got;
        if (oversize[d]) ov_seen[d]++;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int ov_base;
    ov_seen[0] = 0;
    ov_seen[1] = 0;
    reset    = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    drop_i   = '0;
    m_tready = '0;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      check("rst_m_tvalid", 32'(m_tvalid[d]), 32'd0);
      check("rst_s_tready", 32'(s_tready[d]), 32'd0);
      check("rst_level", 32'(level[d]), 32'd0);
      check("rst_aempty", 32'(aempty[d]), 32'd1);
      check("rst_afull", 32'(afull[d]), 32'd0);
      check("rst_oversize", 32'(oversize[d]), 32'd0);
      check("rst_m_tlast", 32'(m_tlast[d]), 32'd0);
    end
    reset = 1'b0;
    step();
    check("rel_s_tready0", 32'(s_tready[0]), 32'd1);
    check("rel_s_tready1", 32'(s_tready[1]), 32'd1);

    // Fill the cut-through FIFO with the consumer stalled, watching the flags.
    for (int i = 0; i < 16; i++) begin
      push(0, 8'(i), 1'b0, 1'b0);
      check("fill_level", 32'(level[0]), 32'(i + 1));
      check("fill_afull", 32'(afull[0]), 32'(i + 1 >= 12));
      check("fill_aempty", 32'(aempty[0]), 32'(i + 1 <= 2));
    end
    check("full_s_tready", 32'(s_tready[0]), 32'd0);
    m_tready[0] = 1'b1;
    drain(0);
    check("drained_level", 32'(level[0]), 32'd0);
    check("drained_aempty", 32'(aempty[0]), 32'd1);

    // Store-and-forward: nothing visible until the tlast beat is in.
    m_tready[1] = 1'b1;
    push(1, 8'hA1, 1'b0, 1'b0);
    check("pkt_hold_a1", 32'(m_tvalid[1]), 32'd0);
    push(1, 8'hA2, 1'b0, 1'b0);
    step();
    check("pkt_hold_a2", 32'(m_tvalid[1]), 32'd0);
    push(1, 8'hA3, 1'b1, 1'b0);
    check("pkt_hold_a3", 32'(m_tvalid[1]), 32'd0);
    step();
    check("pkt_latency", 32'(m_tvalid[1]), 32'd1);
    drain(1);

    // Full FIFO with simultaneous traffic: one-cycle recovery, then 1 beat/cycle.
    m_tready[0] = 1'b0;
    for (int i = 0; i < 16; i++) push(0, 8'(8'h80 + i), 1'b0, 1'b0);
    check("stream_full", 32'(level[0]), 32'd16);
    m_tready[0] = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 32; i++) push(0, 8'($urandom), 1'(i == 31), 1'b0);
    check("stream_cycles", 32'(cyc - c0), 32'd33);
    drain(0);

    // Oversize packet: 20 beats through a 16-beat store-and-forward FIFO.
    ov_base = ov_seen[1];
    m_tready[1] = 1'b0;
    for (int i = 0; i < 16; i++) push(1, 8'(8'h40 + i), 1'b0, 1'b0);
    repeat (3) step();
    check("ov_pulse", 32'(ov_seen[1] - ov_base), 32'd1);
    check("ov_level", 32'(level[1]), 32'd16);
    check("ov_valid", 32'(m_tvalid[1]), 32'd1);
    m_tready[1] = 1'b1;
    for (int i = 16; i < 20; i++) push(1, 8'(8'h40 + i), 1'(i == 19), 1'b0);
    drain(1);
    check("ov_single", 32'(ov_seen[1] - ov_base), 32'd1);

`ifdef SYNC_PACKET_FIFO_DROP_EN
    // Drop the open packet while a committed one waits.
    m_tready[1] = 1'b0;
    push(1, 8'h11, 1'b0, 1'b0);
    push(1, 8'h12, 1'b1, 1'b0);
    push(1, 8'h21, 1'b0, 1'b0);
    push(1, 8'h22, 1'b0, 1'b0);
    check("drop_before", 32'(level[1]), 32'd4);
    drop_i[1] = 1'b1;
    if (!forced) pend.delete();
    step();
    drop_i[1] = 1'b0;
    check("drop_after", 32'(level[1]), 32'(held_beats(1)));
    check("drop_after_abs", 32'(level[1]), 32'd2);
    m_tready[1] = 1'b1;
    drain(1);
    check("drop_drained", 32'(level[1]), 32'd0);
`endif

    // Reset while holding beats discards them.
    m_tready[0] = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level[0]), 32'd5);
    check("pre_rst_valid", 32'(m_tvalid[0]), 32'd1);
    reset = 1'b1;
    step();
    exp0.delete();
    exp1.delete();
    pend.delete();
    forced = 0;
    check("mid_rst_valid", 32'(m_tvalid[0]), 32'd0);
    check("mid_rst_level", 32'(level[0]), 32'd0);
    check("mid_rst_s_tready", 32'(s_tready[0]), 32'd0);
    reset = 1'b0;
    check("mid_rst_s_tready_hold", 32'(s_tready[0]), 32'd0);
    step();
    check("post_rst_s_tready", 32'(s_tready[0]), 32'd1);

    // Randomised traffic on both instances with random consumer stalls.
    ov_base  = ov_seen[1];
    ov_exp   = 0;
    rnd_done = 0;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 150; i++) begin
              push(0, 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
              repeat ($urandom_range(0, 2)) step();
            end
          end
          begin
            for (int i = 0; i < 150; i++) begin
              logic drp;
              drp = 1'b0;
`ifdef SYNC_PACKET_FIFO_DROP_EN
              drp = 1'($urandom_range(0, 15) == 0);
`endif
              push(1, 8'($urandom), 1'($urandom_range(0, 7) == 0), drp);
              repeat ($urandom_range(0, 1)) step();
            end
            push(1, 8'hEE, 1'b1, 1'b0);
          end
        join
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          m_tready = 2'($urandom);
          step();
        end
      end
    join
    m_tready = 2'b11;
    drain(0);
    drain(1);
    for (int d = 0; d < 2; d++) begin
      check("end_level", 32'(level[d]), 32'd0);
      check("end_aempty", 32'(aempty[d]), 32'd1);
      check("end_afull", 32'(afull[d]), 32'd0);
      check("end_valid", 32'(m_tvalid[d]), 32'd0);
    end
    check("rnd_oversize1", 32'(ov_seen[1] - ov_base), 32'(ov_exp));
    check("rnd_oversize0", 32'(ov_seen[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
